// File: rtl/des_sbox_sequencer_pkg.sv
// Shared constants, types and S-box contents for the DES S-layer sequencer.
// Optional build macro used by this slice: DES_SBOX_DUAL_LOOKUP_EN.
package des_sbox_pkg;

    localparam int NUM_SBOX = 8;
    localparam int CHUNK_W  = 6;
    localparam int NIB_W    = 4;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;

    typedef logic [2:0] sbox_idx_t;

    // Standard S1..S8 tables, row-major (row = outer bits, col = inner four bits).
    // S1 is the leftmost 256-bit group; within a group entry 0 is the top nibble.
    localparam logic [0:NUM_SBOX-1][0:63][NIB_W-1:0] SBOX_ROM = {
        256'hE4D12FB83A6C59070F74E2D1A6CB953841E8D62BFC973A50FC8249175B3EA06D,
        256'hF18E6B34972DC05A3D47F28EC01A69B50E7BA4D158C6932FD8A13F42B67C05E9,
        256'hA09E63F51DC7B428D709346A285ECBF1D6498F30B12C5AE71AD069874FE3B52C,
        256'h7DE3069A1285BC4FD8B56F03472C1AE9A690CB7DF13E52843F06A1D8945BC72E,
        256'h2C417AB6853FD0E9EB2C47D150FA3986421BAD78F9C5630EB8C71E2D6F09A453,
        256'hC1AF92680D34E75BAF427C9561DE0B389EF528C3704A1DB6432C95FABE17608D,
        256'h4B2EF08D3C975A61D0B7491AE35C2F8614BDC37EAF6805926BD814A7950FE23C,
        256'hD2846FB1A93E50C71FD8A374C56B0E927B419CE206ADF35821E74A8DFC90356B
    };

    // Chunk k of a DES-ordered 48-bit word (bit 1 = MSB).
    function automatic logic [1:CHUNK_W] chunk_of(input logic [1:NUM_SBOX*CHUNK_W] w,
                                                  input sbox_idx_t k);
        return w[int'(k)*CHUNK_W+1 +: CHUNK_W];
    endfunction

endpackage

// File: rtl/des_sbox_sequencer_bank.sv
// S-box tables and the selectable bank that fronts them.
// des_sbox_table folds the linear 6-bit index into row/column internally.
module des_sbox_table
    import des_sbox_pkg::*;
#(
    parameter int SBOX_ID = 0
) (
    input  logic [1:CHUNK_W] chunk,
    output logic [1:NIB_W]   nibble
);
    logic [5:0] entry;

    // Row is the outer bit pair, column the middle four bits.
    assign entry  = {chunk[1], chunk[6], chunk[2:5]};
    assign nibble = SBOX_ROM[SBOX_ID][entry];
endmodule

// One lookup per cycle: all eight tables see the chunk, sel picks the result.
module des_sbox_bank
    import des_sbox_pkg::*;
(
    input  sbox_idx_t        sel,
    input  logic [1:CHUNK_W] chunk,
    output logic [1:NIB_W]   nibble
);
    logic [NUM_SBOX-1:0][NIB_W-1:0] nibs;

    for (genvar s = 0; s < NUM_SBOX; s++) begin : g_tbl
        des_sbox_table #(.SBOX_ID(s)) u_tbl (
            .chunk  (chunk),
            .nibble (nibs[s])
        );
    end

    assign nibble = nibs[sel];
endmodule

// File: rtl/des_sbox_sequencer.sv
// Time-multiplexed DES S-layer: latches a 48-bit word, walks S1..S8 one
// chunk per cycle (two with DES_SBOX_DUAL_LOOKUP_EN) and presents the
// 32-bit result on a valid/ready port.
module des_sbox_sequencer
    import des_sbox_pkg::*;
#(
    parameter bit CLEAR_ON_IDLE = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:48] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [1:32] out_data,
    output logic        busy
);
    localparam logic [1:0] S_IDLE = 2'(IDLE);
    localparam logic [1:0] S_RUN  = 2'(RUN);
    localparam logic [1:0] S_DONE = 2'(DONE);

`ifdef DES_SBOX_DUAL_LOOKUP_EN
    localparam sbox_idx_t IDX_STEP = 3'd2;
    localparam sbox_idx_t LAST_IDX = 3'd6;
`else
    localparam sbox_idx_t IDX_STEP = 3'd1;
    localparam sbox_idx_t LAST_IDX = 3'd7;
`endif

    logic [1:0]   state;
    sbox_idx_t    idx;
    logic [1:48]  lat;
    logic [1:6]   chunk0;
    logic [1:4]   nib0;

    assign chunk0 = chunk_of(lat, idx);

    des_sbox_bank u_bank0 (
        .sel    (idx),
        .chunk  (chunk0),
        .nibble (nib0)
    );

`ifdef DES_SBOX_DUAL_LOOKUP_EN
    sbox_idx_t    idx1;
    logic [1:6]   chunk1;
    logic [1:4]   nib1;

    // idx is always even here, so idx+1 never wraps.
    assign idx1   = idx + 3'd1;
    assign chunk1 = chunk_of(lat, idx1);

    des_sbox_bank u_bank1 (
        .sel    (idx1),
        .chunk  (chunk1),
        .nibble (nib1)
    );
`endif

    assign in_ready = (state == S_IDLE);
    assign busy     = (state != S_IDLE);

    // Control FSM plus result assembly; out_data only changes in RUN or on release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            idx       <= '0;
            lat       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        lat   <= in_data;
                        idx   <= '0;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    out_data[int'(idx)*NIB_W+1 +: NIB_W] <= nib0;
`ifdef DES_SBOX_DUAL_LOOKUP_EN
                    out_data[int'(idx1)*NIB_W+1 +: NIB_W] <= nib1;
`endif
                    idx <= idx + IDX_STEP;
                    if (idx == LAST_IDX) begin
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                        if (CLEAR_ON_IDLE) out_data <= '0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
